// File: rtl/rf_wb_sched.sv
// Write-back scheduler: round-robin sharing of the register-file write port
// between EXU (wb0) and LSU (wb1), with a per-register pending-write scoreboard.
module rf_wb_sched #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   output logic                  issue_ready,
   input  logic                  wb0_valid,
   input  logic [ADDR_WIDTH-1:0] wb0_addr,
   input  logic [DATA_WIDTH-1:0] wb0_data,
   output logic                  wb0_ready,
   input  logic                  wb1_valid,
   input  logic [ADDR_WIDTH-1:0] wb1_addr,
   input  logic [DATA_WIDTH-1:0] wb1_data,
   output logic                  wb1_ready,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   input  logic [ADDR_WIDTH-1:0] chk_addr1,
   input  logic [ADDR_WIDTH-1:0] chk_addr2,
   output logic                  chk_busy1,
   output logic                  chk_busy2,
   output logic                  sb_err
);

   localparam int NREG = 2**ADDR_WIDTH;

   logic [CNT_WIDTH-1:0]  r_cnt [NREG];
   logic                  r_rr_ptr;
   logic                  r_wen_p1;
   logic [ADDR_WIDTH-1:0] r_waddr_p1;
   logic [DATA_WIDTH-1:0] r_wdata_p1;
   logic                  r_sb_err;

   logic                  w_gnt0;
   logic                  w_gnt1;
   logic [ADDR_WIDTH-1:0] w_gnt_addr;
   logic [DATA_WIDTH-1:0] w_gnt_data;
   logic                  w_wr_fire;
   logic                  w_issue_inc;
   logic                  w_underflow;
   logic [NREG-1:0]       w_inc;
   logic [NREG-1:0]       w_dec;

   // r_rr_ptr = 0 favours wb0 on contention, 1 favours wb1
   assign w_gnt0     = wb0_valid & (~wb1_valid | ~r_rr_ptr);
   assign w_gnt1     = wb1_valid & ~w_gnt0;
   assign wb0_ready  = w_gnt0;
   assign wb1_ready  = w_gnt1;
   assign w_gnt_addr = w_gnt1 ? wb1_addr : wb0_addr;
   assign w_gnt_data = w_gnt1 ? wb1_data : wb0_data;
   assign w_wr_fire  = (w_gnt0 | w_gnt1) && (w_gnt_addr != '0);

   assign issue_ready = (issue_rd == '0) || (r_cnt[issue_rd] != '1);
   assign w_issue_inc = issue_valid && issue_ready && (issue_rd != '0);
   assign w_underflow = r_wen_p1 && (r_cnt[r_waddr_p1] == '0);

   assign chk_busy1 = (chk_addr1 != '0) && (r_cnt[chk_addr1] != '0);
   assign chk_busy2 = (chk_addr2 != '0) && (r_cnt[chk_addr2] != '0);

   assign rf_wen   = r_wen_p1;
   assign rf_waddr = r_waddr_p1;
   assign rf_wdata = r_wdata_p1;
   assign sb_err   = r_sb_err;

   always_comb begin
      w_inc = '0;
      w_dec = '0;
      if (w_issue_inc) w_inc[issue_rd] = 1'b1;
      if (r_wen_p1)    w_dec[r_waddr_p1] = 1'b1;
   end

   // ---- p0 -> p1: grant captured into the write-port register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr   <= 1'b0;
         r_wen_p1   <= 1'b0;
         r_waddr_p1 <= '0;
         r_wdata_p1 <= '0;
         r_sb_err   <= 1'b0;
      end else begin
         if (w_gnt0)      r_rr_ptr <= 1'b1;
         else if (w_gnt1) r_rr_ptr <= 1'b0;
         r_wen_p1 <= w_wr_fire;
         if (w_wr_fire) begin
            r_waddr_p1 <= w_gnt_addr;
            r_wdata_p1 <= w_gnt_data;
         end
         r_sb_err <= r_sb_err | w_underflow;
      end
   end

   // Simultaneous issue and commit to one register cancel out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (w_inc[i] && !w_dec[i])
               r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
            else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0))
               r_cnt[i] <= r_cnt[i] - CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Bench for rf_wb_sched: directed vector table, hand-written corner sequences,
// then random traffic against a counter-array reference model.
module tb_rf_wb_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic        wb0_valid, wb1_valid;
   logic [4:0]  wb0_addr, wb1_addr;
   logic [31:0] wb0_data, wb1_data;
   logic        wb0_ready, wb1_ready;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  chk_addr1, chk_addr2;
   logic        chk_busy1, chk_busy2;
   logic        sb_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rf_wb_sched #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
      .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
      .chk_busy1(chk_busy1), .chk_busy2(chk_busy2), .sb_err(sb_err)
   );

   typedef struct {
      logic        iv;  logic [4:0] ird;
      logic        v0;  logic [4:0] a0; logic [31:0] d0;
      logic        v1;  logic [4:0] a1; logic [31:0] d1;
      logic        ir, r0, r1, wen;
      logic [4:0]  wa;  logic [31:0] wd;
      logic        b1, b2, err;
   } vec_t;

   vec_t tbl [17];

   // Reference model state: pending-write count per register plus write port
   int          m_cnt [32];
   bit          m_rr;
   bit          m_wen;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   bit          m_err;

   function automatic vec_t mk(input logic iv, input logic [4:0] ird,
                               input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic ir, input logic r0, input logic r1,
                               input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                               input logic b1, input logic b2, input logic err);
      vec_t v;
      v.iv = iv; v.ird = ird; v.v0 = v0; v.a0 = a0; v.d0 = d0;
      v.v1 = v1; v.a1 = a1; v.d1 = d1; v.ir = ir; v.r0 = r0; v.r1 = r1;
      v.wen = wen; v.wa = wa; v.wd = wd; v.b1 = b1; v.b2 = b2; v.err = err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_rd = 5'd0;
      wb0_valid = 1'b0; wb0_addr = 5'd0; wb0_data = 32'd0;
      wb1_valid = 1'b0; wb1_addr = 5'd0; wb1_data = 32'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hard_reset();
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_rr = 1'b0; m_wen = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_err = 1'b0;
   endtask

   task automatic run_random(input int cycles);
      bit g0, g1, ir, inc, dec;
      logic [4:0]  ga;
      logic [31:0] gd;
      int c;
      g0 = 1'b0; g1 = 1'b0;
      for (int n = 0; n < cycles; n++) begin
         if (!(wb0_valid && !g0)) begin
            wb0_valid = 1'($urandom_range(0, 1));
            wb0_addr  = 5'($urandom_range(0, 7));
            wb0_data  = $urandom;
         end
         if (!(wb1_valid && !g1)) begin
            wb1_valid = 1'($urandom_range(0, 1));
            wb1_addr  = 5'($urandom_range(0, 7));
            wb1_data  = $urandom;
         end
         issue_valid = 1'($urandom_range(0, 1));
         issue_rd    = 5'($urandom_range(0, 7));
         chk_addr1   = 5'($urandom_range(0, 7));
         chk_addr2   = 5'($urandom_range(0, 7));
         #1;
         ir = (issue_rd == 5'd0) || (m_cnt[issue_rd] < 3);
         if (wb0_valid && wb1_valid) begin g0 = (m_rr == 1'b0); g1 = !g0; end
         else begin g0 = wb0_valid; g1 = wb1_valid; end
         chk("rnd issue_ready", 32'(issue_ready), 32'(ir));
         chk("rnd wb0_ready", 32'(wb0_ready), 32'(g0));
         chk("rnd wb1_ready", 32'(wb1_ready), 32'(g1));
         chk("rnd rf_wen", 32'(rf_wen), 32'(m_wen));
         chk("rnd rf_waddr", 32'(rf_waddr), 32'(m_wa));
         chk("rnd rf_wdata", rf_wdata, m_wd);
         chk("rnd chk_busy1", 32'(chk_busy1), 32'((chk_addr1 != 5'd0) && (m_cnt[chk_addr1] != 0)));
         chk("rnd chk_busy2", 32'(chk_busy2), 32'((chk_addr2 != 5'd0) && (m_cnt[chk_addr2] != 0)));
         chk("rnd sb_err", 32'(sb_err), 32'(m_err));
         // advance the model by one clock
         for (int r = 1; r < 32; r++) begin
            c   = m_cnt[r];
            inc = issue_valid && ir && (issue_rd == 5'(r));
            dec = m_wen && (m_wa == 5'(r));
            if (dec && c == 0) m_err = 1'b1;
            if (inc && !dec) m_cnt[r] = c + 1;
            else if (dec && !inc && c > 0) m_cnt[r] = c - 1;
         end
         if (g0) m_rr = 1'b1;
         if (g1) m_rr = 1'b0;
         ga = g1 ? wb1_addr : wb0_addr;
         gd = g1 ? wb1_data : wb0_data;
         m_wen = (g0 || g1) && (ga != 5'd0);
         if (m_wen) begin m_wa = ga; m_wd = gd; end
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      chk_addr1 = 5'd7; chk_addr2 = 5'd3;
      idle();

      tbl[0]  = mk(0,0, 0,0,0,        0,0,0,        1,0,0, 0,0,0,        0,0,0);
      tbl[1]  = mk(1,3, 0,0,0,        0,0,0,        1,0,0, 0,0,0,        0,0,0);
      tbl[2]  = mk(1,4, 0,0,0,        0,0,0,        1,0,0, 0,0,0,        0,1,0);
      tbl[3]  = mk(1,7, 0,0,0,        0,0,0,        1,0,0, 0,0,0,        0,1,0);
      tbl[4]  = mk(1,7, 0,0,0,        0,0,0,        1,0,0, 0,0,0,        1,1,0);
      tbl[5]  = mk(1,7, 0,0,0,        0,0,0,        1,0,0, 0,0,0,        1,1,0);
      tbl[6]  = mk(1,7, 0,0,0,        0,0,0,        0,0,0, 0,0,0,        1,1,0);
      tbl[7]  = mk(0,0, 1,3,32'h11,   1,4,32'h22,   1,1,0, 0,0,0,        1,1,0);
      tbl[8]  = mk(0,0, 1,7,32'h33,   1,4,32'h22,   1,0,1, 1,3,32'h11,   1,1,0);
      tbl[9]  = mk(0,0, 1,7,32'h33,   1,7,32'h44,   1,1,0, 1,4,32'h22,   1,0,0);
      tbl[10] = mk(0,0, 0,0,0,        1,7,32'h44,   1,0,1, 1,7,32'h33,   1,0,0);
      tbl[11] = mk(0,0, 0,0,0,        0,0,0,        1,0,0, 1,7,32'h44,   1,0,0);
      tbl[12] = mk(0,0, 1,7,32'h55,   0,0,0,        1,1,0, 0,7,32'h44,   1,0,0);
      tbl[13] = mk(0,0, 0,0,0,        0,0,0,        1,0,0, 1,7,32'h55,   1,0,0);
      tbl[14] = mk(0,0, 0,0,0,        0,0,0,        1,0,0, 0,7,32'h55,   0,0,0);
      tbl[15] = mk(1,0, 0,0,0,        1,0,32'hFF,   1,0,1, 0,7,32'h55,   0,0,0);
      tbl[16] = mk(0,0, 0,0,0,        0,0,0,        1,0,0, 0,7,32'h55,   0,0,0);

      hard_reset();
      for (int k = 0; k < 17; k++) begin
         issue_valid = tbl[k].iv; issue_rd = tbl[k].ird;
         wb0_valid = tbl[k].v0; wb0_addr = tbl[k].a0; wb0_data = tbl[k].d0;
         wb1_valid = tbl[k].v1; wb1_addr = tbl[k].a1; wb1_data = tbl[k].d1;
         #1;
         chk($sformatf("tbl%0d issue_ready", k), 32'(issue_ready), 32'(tbl[k].ir));
         chk($sformatf("tbl%0d wb0_ready", k), 32'(wb0_ready), 32'(tbl[k].r0));
         chk($sformatf("tbl%0d wb1_ready", k), 32'(wb1_ready), 32'(tbl[k].r1));
         chk($sformatf("tbl%0d rf_wen", k), 32'(rf_wen), 32'(tbl[k].wen));
         chk($sformatf("tbl%0d rf_waddr", k), 32'(rf_waddr), 32'(tbl[k].wa));
         chk($sformatf("tbl%0d rf_wdata", k), rf_wdata, tbl[k].wd);
         chk($sformatf("tbl%0d chk_busy1", k), 32'(chk_busy1), 32'(tbl[k].b1));
         chk($sformatf("tbl%0d chk_busy2", k), 32'(chk_busy2), 32'(tbl[k].b2));
         chk($sformatf("tbl%0d sb_err", k), 32'(sb_err), 32'(tbl[k].err));
         tick();
      end

      // Issue and commit to the same register in one cycle
      hard_reset();
      chk_addr1 = 5'd9;
      issue_valid = 1'b1; issue_rd = 5'd9; tick();
      idle(); wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h99;
      #1 chk("sim wb0_ready", 32'(wb0_ready), 32'd1);
      tick();
      idle(); issue_valid = 1'b1; issue_rd = 5'd9;
      #1;
      chk("sim issue_ready", 32'(issue_ready), 32'd1);
      chk("sim rf_wen", 32'(rf_wen), 32'd1);
      chk("sim rf_waddr", 32'(rf_waddr), 32'd9);
      chk("sim busy during", 32'(chk_busy1), 32'd1);
      tick();
      idle();
      #1 chk("sim busy after", 32'(chk_busy1), 32'd1);
      wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h9A;
      tick(); idle(); tick();
      #1;
      chk("sim busy cleared", 32'(chk_busy1), 32'd0);
      chk("sim sb_err", 32'(sb_err), 32'd0);

      // Write-back to a register with nothing pending
      chk_addr1 = 5'd12;
      wb0_valid = 1'b1; wb0_addr = 5'd12; wb0_data = 32'hC;
      #1 chk("uf wb0_ready", 32'(wb0_ready), 32'd1);
      tick(); idle();
      #1;
      chk("uf rf_wen", 32'(rf_wen), 32'd1);
      chk("uf rf_waddr", 32'(rf_waddr), 32'd12);
      chk("uf rf_wdata", rf_wdata, 32'hC);
      chk("uf sb_err early", 32'(sb_err), 32'd0);
      tick();
      #1 chk("uf sb_err set", 32'(sb_err), 32'd1);
      issue_valid = 1'b1; issue_rd = 5'd5; tick();
      idle(); wb1_valid = 1'b1; wb1_addr = 5'd5; wb1_data = 32'h5; tick();
      idle();
      #1 chk("uf rf_waddr x5", 32'(rf_waddr), 32'd5);
      tick();
      #1 chk("uf sb_err sticky", 32'(sb_err), 32'd1);

      // Asynchronous reset in the middle of a write
      chk_addr1 = 5'd5;
      issue_valid = 1'b1; issue_rd = 5'd5; tick(); tick();
      idle(); wb1_valid = 1'b1; wb1_addr = 5'd6; wb1_data = 32'h66; tick();
      idle();
      #1;
      chk("rst pre busy", 32'(chk_busy1), 32'd1);
      chk("rst pre rf_wen", 32'(rf_wen), 32'd1);
      #1 rst_n = 1'b0;
      #2;
      chk("rst rf_wen", 32'(rf_wen), 32'd0);
      chk("rst chk_busy1", 32'(chk_busy1), 32'd0);
      chk("rst sb_err", 32'(sb_err), 32'd0);
      #1 rst_n = 1'b1;
      wb0_valid = 1'b1; wb0_addr = 5'd2; wb0_data = 32'h1;
      wb1_valid = 1'b1; wb1_addr = 5'd3; wb1_data = 32'h2;
      #1;
      chk("rst wb0_ready", 32'(wb0_ready), 32'd1);
      chk("rst wb1_ready", 32'(wb1_ready), 32'd0);
      tick();

      hard_reset();
      run_random(400);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Write-back scheduler for the 2-read/1-write register file: shares the single write port between two write-back requesters (wb0 = EXU, wb1 = LSU) by round-robin.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards.
- Sits between the execute/memory stages and the register file.
- Drives the register file's wen/waddr/wdata directly from a registered output stage.

Parameters:
- ADDR_WIDTH, 5, register index width; the register file has 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, register data width.
- CNT_WIDTH, 2, width of each pending-write counter; maximum outstanding writes per register is 2**CNT_WIDTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  decode issues an instruction that will write issue_rd.
- issue_rd  in  ADDR_WIDTH  destination register of the issued instruction.
- issue_ready  out  1  issue accepted this cycle.
- wb0_valid  in  1  EXU write-back request.
- wb0_addr  in  ADDR_WIDTH  EXU destination register.
- wb0_data  in  DATA_WIDTH  EXU result.
- wb0_ready  out  1  EXU request granted this cycle.
- wb1_valid, wb1_addr, wb1_data, wb1_ready  as wb0, for the LSU.
- rf_wen  out  1  register file write enable (registered).
- rf_waddr  out  ADDR_WIDTH  register file write address (registered).
- rf_wdata  out  DATA_WIDTH  register file write data (registered).
- chk_addr1, chk_addr2  in  ADDR_WIDTH  source registers under hazard check.
- chk_busy1, chk_busy2  out  1  source has an uncommitted pending write.
- sb_err  out  1  sticky flag: a write-back retired with no pending issue.

Behaviour:
- Reset (rst_n=0, async) forces all of the following. Any in-flight handshake is dropped.
  - All counters = 0.
  - rr_ptr = wb0.
  - rf_wen = 0, rf_waddr = 0, rf_wdata = 0.
  - sb_err = 0.
- Arbitration (combinational grant, one grant per cycle):
  - One valid requester: that requester is granted.
  - Both valid: the requester selected by rr_ptr is granted.
  - wbN_ready = grant to N. A handshake completes when valid && ready.
  - The output stage always accepts, so a lone valid requester is granted in the same cycle.
- rr_ptr update: after a grant to N, rr_ptr points to the other requester. rr_ptr is unchanged when nothing is granted.
- Request stability: a requester holds valid, addr and data stable until its ready is asserted.
- Output stage (latency 1): the grant in cycle T drives rf_wen/rf_waddr/rf_wdata during cycle T+1.
  - The register file commits at the end of T+1.
  - rf_wen = 0 in T+1 when nothing was granted in T, or when the granted addr is 0. The x0 handshake still completes.
  - rf_waddr and rf_wdata hold their last values while rf_wen = 0.
- Scoreboard: cnt[r] per register, CNT_WIDTH bits; cnt[0] is always 0.
  - Increment: on issue_valid && issue_ready with issue_rd != 0.
  - issue_ready = 0 iff issue_rd != 0 and cnt[issue_rd] is all-ones. issue_rd = 0 is always ready and has no effect.
  - Decrement: at the end of a cycle with rf_wen = 1, on cnt[rf_waddr].
  - Same register incremented and decremented in the same cycle: cnt is unchanged.
  - Decrement of a counter already at 0: counter stays 0 and sb_err is set to 1. sb_err stays 1 until reset. The write itself is still performed.
- Hazard check: chk_busyK = (chk_addrK != 0) && (cnt[chk_addrK] != 0), combinational from the registered counters.
  - busy clears in the cycle after the commit edge. Data read from the register file in that cycle is the new value.
  - There is no bypass.

Test Plan:
- Reset mid-operation: with cnt[5] = 2 and rf_wen = 1, pulse rst_n low for 3 ns between edges -> rf_wen, chk_busy and sb_err go 0 immediately; the next request after release (wb0 and wb1 both valid) is granted to wb0.
- Contention: wb0 (x3 = 0x11) and wb1 (x4 = 0x22) both held valid -> wb0_ready in T; wb1_ready in T+1; rf writes x3 = 0x11 in T+1 and x4 = 0x22 in T+2; rr_ptr alternates while both remain valid.
- Scoreboard: issue rd = 7 twice -> chk_busy1 (chk_addr1 = 7) = 1; issue a third time -> issue_ready = 1, cnt = 3; a fourth issue -> issue_ready = 0; two write-backs to x7 -> busy remains 1; after the third commit, busy = 0 in the next cycle.
- Simultaneous events: cnt[9] = 1, issue rd = 9 in the same cycle rf_wen = 1 with rf_waddr = 9 -> cnt[9] stays 1 and chk_busy stays 1.
- x0 handling: issue rd = 0 -> issue_ready = 1, no counter change; wb1 writes x0 = 0xFF -> wb1_ready = 1, rf_wen = 0 in the next cycle, sb_err = 0.
- Underflow: write-back to x12 with cnt[12] = 0 -> rf_wen = 1 writing x12; sb_err = 1 from the next cycle and stays set through later traffic until reset.
